ov7670_cfg_seq: RTL and testbench
=================================

// Module: ov7670_cfg_seq
// PURPOSE
//  Boot-time register sequencer for the OV7670 camera. Walks a fixed register table and
//  drives the single-slave, write-only SCCB master: start/busy/wait-intr-clr/intr-clr.
//  Sits between the top-level init logic and the SCCB master.
//  Reports done/error so the capture path can be enabled only after configuration.
// PARAMETERS
//  SLAVE_ID     8'h42   SCCB write ID placed in SCCB data [23:16]
//  NUM_ENTRIES  8'd64   table depth; sequence ends at this index if no END marker is hit
//  DELAY_CYC    20'd1000000  wait length for a DELAY marker entry (soft-reset settle)
//  GAP_CYC      8'd16   minimum idle cycles between transactions (bus free time)
//  TIMEOUT_CYC  16'd4096  watchdog limit per handshake phase (OV7670_CFG_TIMEOUT_EN only)
// PORTS
//  I_CLK                input   1   system clock, same clock as the SCCB master
//  I_RST                input   1   asynchronous, active-high reset
//  I_CFG_START          input   1   pulse: run the table from index 0
//  O_CFG_BUSY           output  1   high from accepted start until DONE/ERROR
//  O_CFG_DONE           output  1   sticky high after a clean end of table
//  O_CFG_ERR            output  1   sticky high after a watchdog timeout
//  O_CFG_IDX            output  8   index of the current (or last) table entry
//  O_SCCB_DATA          output 32   {8'h00, SLAVE_ID, sub_addr, wdata} to the master I_DATA
//  O_SCCB_START         output  1   to the master I_START
//  I_SCCB_BUSY          input   1   from the master O_BUSY
//  I_SCCB_WAIT_INTR_CLR input   1   from the master O_WAIT_INTR_CLR
//  O_SCCB_INTR_CLR      output  1   to the master I_INTR_CLR
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, index 0. Reset may assert at any time, including
//   mid-transaction. The master must share the same reset.
//  Table entry: 16 bits {sub_addr, wdata}. Two markers:
//   16'hFFFF = END
//   16'hFFF0 = DELAY, wait DELAY_CYC cycles with no bus transaction
//  FSM states and transitions:
//   IDLE   -> FETCH on I_CFG_START. IDX<=0, DONE/ERR<=0, BUSY<=1.
//   FETCH  -> ROM read, 1 cycle registered.
//             IDX==NUM_ENTRIES or END marker -> DONE. DELAY marker -> DELAY. Else -> LAUNCH.
//   LAUNCH -> latch O_SCCB_DATA, hold O_SCCB_START=1 until I_SCCB_BUSY=1, then -> XFER.
//             START drops the cycle after BUSY is seen.
//   XFER   -> wait for I_SCCB_WAIT_INTR_CLR=1, then -> CLEAR.
//   CLEAR  -> hold O_SCCB_INTR_CLR=1 until I_SCCB_WAIT_INTR_CLR=0, then drop it -> GAP.
//   GAP    -> count GAP_CYC cycles, IDX<=IDX+1 -> FETCH.
//   DELAY  -> count DELAY_CYC cycles, IDX<=IDX+1 -> FETCH.
//   DONE   -> BUSY<=0, DONE<=1. I_CFG_START restarts from index 0.
//   ERROR  -> BUSY<=0, ERR<=1. I_CFG_START restarts from index 0.
//  O_SCCB_DATA stays stable from LAUNCH until CLEAR exits. The master reads it live while
//   busy, so it must not change during the transaction.
//  O_SCCB_START and O_SCCB_INTR_CLR are never high together. Neither is high outside
//   LAUNCH/CLEAR.
//  I_CFG_START while BUSY=1: ignored.
//  I_CFG_START in the same cycle as the DONE entry: ignored; takes effect from DONE.
//  Counters are sized from their parameters and saturate-free: cleared on every entry
//   to GAP or DELAY.
//  IDX wraps never: the NUM_ENTRIES compare ends the run first.
// CONFIGURATION
//  `OV7670_CFG_TIMEOUT_EN defined:
//   - A watchdog counts cycles in LAUNCH, XFER and CLEAR; it resets on each state change.
//   - Reaching TIMEOUT_CYC -> ERROR. START and INTR_CLR drop the same cycle.
//   - IDX holds the failing entry.
//  Not defined: no watchdog; O_CFG_ERR tied 0; ERROR state unreachable.
// STRUCTURE
//  ov7670_cfg_pkg:
//   - state encodings
//   - END/DELAY marker constants
//   - entry width (16)
//   - SCCB data packing function
//  Sub-module ov7670_cfg_rom: synchronous case-ROM, 8-bit addr in, 16-bit entry out,
//   1-cycle latency.
//  Top: FSM, counters and the SCCB handshake.
// TESTING (bench pairs the DUT with the SCCB master and an SIO_D ACK model)
//  1. Table {12 80, FFF0, 11 01, FFFF}, DELAY_CYC=100, pulse start:
//     - 2 SCCB frames: 42/12/80, then 42/11/01.
//     - >=100 cycles between frame 1 and 2.
//     - DONE=1, IDX=3.
//  2. Table with no END, NUM_ENTRIES=4: exactly 4 frames, DONE=1, IDX=4.
//  3. Start pulses during a run: no restart, frame count unchanged.
//     Start after DONE: DONE clears, frames repeat from index 0.
//  4. Reset asserted mid-XFER of entry 2:
//     - All outputs 0 next edge.
//     - A new start begins at index 0 with no duplicate START to the master.
//  5. Timeout macro on, TIMEOUT_CYC=64, I_SCCB_BUSY forced 0:
//     - ERR=1 after 64 cycles in LAUNCH, IDX=0, START=0.
//     - Macro off: hangs in LAUNCH, ERR=0.
//  6. Checker for every frame:
//     - O_SCCB_DATA stable while BUSY or WAIT_INTR_CLR.
//     - START and INTR_CLR never high together.
//     - >=GAP_CYC idle cycles between frames.

Source files
------------

// File: rtl/ov7670_cfg_pkg.sv
// Shared types and constants for the OV7670 boot-time register sequencer.
// These are the state encodings, the table marker values and the packing of an SCCB frame word.
package ov7670_cfg_pkg;

    localparam int ENTRY_W = 16;

    localparam logic [ENTRY_W-1:0] ENTRY_END   = 16'hFFFF;
    localparam logic [ENTRY_W-1:0] ENTRY_DELAY = 16'hFFF0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LAUNCH,
        ST_XFER,
        ST_CLEAR,
        ST_GAP,
        ST_DELAY,
        ST_DONE,
        ST_ERROR
    } state_t;

    // The SCCB master takes {pad, slave id, sub address, write data}.
    function automatic logic [31:0] pack_sccb(input logic [7:0] slave_id,
                                              input logic [ENTRY_W-1:0] entry);
        return {8'h00, slave_id, entry};
    endfunction

endpackage

// File: rtl/ov7670_cfg_rom.sv
// Synchronous case-ROM holding the OV7670 register table. Reads have a latency of one cycle.
// TABLE_SEL 0 is the production table. Selections 1 and 2 are short tables for bring-up.
module ov7670_cfg_rom
    import ov7670_cfg_pkg::*;
#(
    parameter int TABLE_SEL = 0
) (
    input  logic               clk,
    input  logic [7:0]         addr,
    output logic [ENTRY_W-1:0] entry
);

    logic [ENTRY_W-1:0] rom_word;

    always_comb begin
        rom_word = ENTRY_END;
        if (TABLE_SEL == 1) begin
            case (addr)
                8'd0:    rom_word = 16'h1280;
                8'd1:    rom_word = ENTRY_DELAY;
                8'd2:    rom_word = 16'h1101;
                default: rom_word = ENTRY_END;
            endcase
        end else if (TABLE_SEL == 2) begin
            // No END marker: the run must be stopped by the entry count.
            case (addr)
                8'd0:    rom_word = 16'h3A04;
                8'd1:    rom_word = 16'h40D0;
                8'd2:    rom_word = 16'h8C00;
                8'd3:    rom_word = 16'h1101;
                default: rom_word = 16'h0000;
            endcase
        end else begin
            case (addr)
                8'd0:    rom_word = 16'h1280;  // COM7 soft reset
                8'd1:    rom_word = ENTRY_DELAY;
                8'd2:    rom_word = 16'h1214;  // QVGA, RGB
                8'd3:    rom_word = 16'h40D0;  // RGB565, full range
                8'd4:    rom_word = 16'h8C00;
                8'd5:    rom_word = 16'h3A04;
                8'd6:    rom_word = 16'h1101;
                8'd7:    rom_word = 16'h0C04;
                8'd8:    rom_word = 16'h3E19;
                default: rom_word = ENTRY_END;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        entry <= rom_word;
    end

endmodule

// File: rtl/ov7670_cfg_seq.sv
// OV7670 boot sequencer. It walks the register ROM and drives the write-only SCCB master handshake.
// Define OV7670_CFG_TIMEOUT_EN to add a per-phase watchdog that ends the run in ERROR.
module ov7670_cfg_seq
    import ov7670_cfg_pkg::*;
#(
    parameter logic [7:0]  SLAVE_ID    = 8'h42,
    parameter logic [7:0]  NUM_ENTRIES = 8'd64,
    parameter logic [19:0] DELAY_CYC   = 20'd1000000,
    parameter logic [7:0]  GAP_CYC     = 8'd16,
    parameter logic [15:0] TIMEOUT_CYC = 16'd4096,
    parameter int          TABLE_SEL   = 0
) (
    input  logic        I_CLK,
    input  logic        I_RST,
    input  logic        I_CFG_START,
    output logic        O_CFG_BUSY,
    output logic        O_CFG_DONE,
    output logic        O_CFG_ERR,
    output logic [7:0]  O_CFG_IDX,
    output logic [31:0] O_SCCB_DATA,
    output logic        O_SCCB_START,
    input  logic        I_SCCB_BUSY,
    input  logic        I_SCCB_WAIT_INTR_CLR,
    output logic        O_SCCB_INTR_CLR
);

    localparam int GAP_W   = $clog2(int'(GAP_CYC) + 2);
    localparam int DELAY_W = $clog2(int'(DELAY_CYC) + 2);

    state_t               state_reg;
    logic [7:0]           idx_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic [31:0]          data_reg;
    logic                 start_reg;
    logic                 clr_reg;
    logic                 fetch_phase_reg;
    logic [GAP_W-1:0]     gap_cnt_reg;
    logic [DELAY_W-1:0]   delay_cnt_reg;
    logic [ENTRY_W-1:0]   rom_entry;
    logic                 phase_done;
    logic                 gap_last;
    logic                 delay_last;

    ov7670_cfg_rom #(
        .TABLE_SEL (TABLE_SEL)
    ) u_rom (
        .clk   (I_CLK),
        .addr  (idx_reg),
        .entry (rom_entry)
    );

    assign gap_last   = (32'(gap_cnt_reg) + 32'd1 >= 32'(GAP_CYC));
    assign delay_last = (32'(delay_cnt_reg) + 32'd1 >= 32'(DELAY_CYC));

    // Exit condition of whichever handshake phase is active.
    always_comb begin
        phase_done = 1'b0;
        case (state_reg)
            ST_LAUNCH: phase_done = I_SCCB_BUSY;
            ST_XFER:   phase_done = I_SCCB_WAIT_INTR_CLR;
            ST_CLEAR:  phase_done = !I_SCCB_WAIT_INTR_CLR;
            default:   phase_done = 1'b0;
        endcase
    end

`ifdef OV7670_CFG_TIMEOUT_EN
    localparam int WD_W = $clog2(int'(TIMEOUT_CYC) + 2);

    logic [WD_W-1:0] wd_cnt_reg;
    logic            err_reg;
    logic            in_handshake;
    logic            wd_expired;

    assign in_handshake = (state_reg == ST_LAUNCH) || (state_reg == ST_XFER) ||
                          (state_reg == ST_CLEAR);
    assign wd_expired   = (32'(wd_cnt_reg) + 32'd1 >= 32'(TIMEOUT_CYC));
    assign O_CFG_ERR    = err_reg;
`else
    // No watchdog in this build, so the error flag stays low.
    assign O_CFG_ERR = 1'b0 & (|TIMEOUT_CYC);
`endif

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_reg       <= ST_IDLE;
            idx_reg         <= 8'd0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            data_reg        <= 32'd0;
            start_reg       <= 1'b0;
            clr_reg         <= 1'b0;
            fetch_phase_reg <= 1'b0;
            gap_cnt_reg     <= '0;
            delay_cnt_reg   <= '0;
`ifdef OV7670_CFG_TIMEOUT_EN
            wd_cnt_reg      <= '0;
            err_reg         <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (I_CFG_START) begin
                        idx_reg         <= 8'd0;
                        done_reg        <= 1'b0;
                        busy_reg        <= 1'b1;
                        fetch_phase_reg <= 1'b0;
                        state_reg       <= ST_FETCH;
`ifdef OV7670_CFG_TIMEOUT_EN
                        err_reg         <= 1'b0;
`endif
                    end
                end
                ST_FETCH: begin
                    // The first cycle lets the registered ROM catch up with idx_reg.
                    if (!fetch_phase_reg) begin
                        fetch_phase_reg <= 1'b1;
                    end else if (idx_reg == NUM_ENTRIES || rom_entry == ENTRY_END) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else if (rom_entry == ENTRY_DELAY) begin
                        delay_cnt_reg <= '0;
                        state_reg     <= ST_DELAY;
                    end else begin
                        data_reg  <= pack_sccb(SLAVE_ID, rom_entry);
                        start_reg <= 1'b1;
                        state_reg <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (phase_done) begin
                        start_reg <= 1'b0;
                        state_reg <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (phase_done) begin
                        clr_reg   <= 1'b1;
                        state_reg <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (phase_done) begin
                        clr_reg     <= 1'b0;
                        gap_cnt_reg <= '0;
                        state_reg   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_last) begin
                        idx_reg         <= idx_reg + 8'd1;
                        fetch_phase_reg <= 1'b0;
                        state_reg       <= ST_FETCH;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
                    end
                end
                ST_DELAY: begin
                    if (delay_last) begin
                        idx_reg         <= idx_reg + 8'd1;
                        fetch_phase_reg <= 1'b0;
                        state_reg       <= ST_FETCH;
                    end else begin
                        delay_cnt_reg <= delay_cnt_reg + DELAY_W'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
`ifdef OV7670_CFG_TIMEOUT_EN
            // A timeout overrides any handshake progress in the same cycle.
            if (in_handshake && wd_expired) begin
                state_reg  <= ST_ERROR;
                start_reg  <= 1'b0;
                clr_reg    <= 1'b0;
                busy_reg   <= 1'b0;
                err_reg    <= 1'b1;
                wd_cnt_reg <= '0;
            end else if (in_handshake && !phase_done) begin
                wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
            end else begin
                wd_cnt_reg <= '0;
            end
`endif
        end
    end

    assign O_CFG_BUSY      = busy_reg;
    assign O_CFG_DONE      = done_reg;
    assign O_CFG_IDX       = idx_reg;
    assign O_SCCB_DATA     = data_reg;
    assign O_SCCB_START    = start_reg;
    assign O_SCCB_INTR_CLR = clr_reg;

endmodule

// File: tb/tb_ov7670_cfg_seq.sv
// Directed bench for ov7670_cfg_seq. It drives three sequencer instances, and two of them are paired with a behavioural SCCB master.
// The expectations for the watchdog follow OV7670_CFG_TIMEOUT_EN.
module tb_ov7670_cfg_seq;

    localparam int XFER_LEN = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_asserts = 0;
    int n_fail = 0;

    // Channel 0 = dut_a (table 1), channel 1 = dut_b (table 2, no END)
    logic [1:0]  cfg_start, cfg_busy, cfg_done, cfg_err;
    logic [1:0]  sccb_start, sccb_clr, m_busy, m_wait;
    logic [7:0]  cfg_idx [2];
    logic [31:0] sccb_data [2];

    logic        start_c, busy_c, done_c, err_c, sstart_c, clr_c;
    logic [7:0]  idx_c;
    logic [31:0] data_c;
    logic        tie_lo;
    assign tie_lo = 1'b0;

    ov7670_cfg_seq #(
        .SLAVE_ID (8'h42), .NUM_ENTRIES (8'd64), .DELAY_CYC (20'd100),
        .GAP_CYC (8'd16), .TIMEOUT_CYC (16'd4096), .TABLE_SEL (1)
    ) dut_a (
        .I_CLK (clk), .I_RST (rst), .I_CFG_START (cfg_start[0]),
        .O_CFG_BUSY (cfg_busy[0]), .O_CFG_DONE (cfg_done[0]), .O_CFG_ERR (cfg_err[0]),
        .O_CFG_IDX (cfg_idx[0]), .O_SCCB_DATA (sccb_data[0]), .O_SCCB_START (sccb_start[0]),
        .I_SCCB_BUSY (m_busy[0]), .I_SCCB_WAIT_INTR_CLR (m_wait[0]),
        .O_SCCB_INTR_CLR (sccb_clr[0])
    );

    ov7670_cfg_seq #(
        .SLAVE_ID (8'h42), .NUM_ENTRIES (8'd4), .DELAY_CYC (20'd100),
        .GAP_CYC (8'd16), .TIMEOUT_CYC (16'd4096), .TABLE_SEL (2)
    ) dut_b (
        .I_CLK (clk), .I_RST (rst), .I_CFG_START (cfg_start[1]),
        .O_CFG_BUSY (cfg_busy[1]), .O_CFG_DONE (cfg_done[1]), .O_CFG_ERR (cfg_err[1]),
        .O_CFG_IDX (cfg_idx[1]), .O_SCCB_DATA (sccb_data[1]), .O_SCCB_START (sccb_start[1]),
        .I_SCCB_BUSY (m_busy[1]), .I_SCCB_WAIT_INTR_CLR (m_wait[1]),
        .O_SCCB_INTR_CLR (sccb_clr[1])
    );

    ov7670_cfg_seq #(
        .SLAVE_ID (8'h42), .NUM_ENTRIES (8'd64), .DELAY_CYC (20'd100),
        .GAP_CYC (8'd16), .TIMEOUT_CYC (16'd64), .TABLE_SEL (1)
    ) dut_c (
        .I_CLK (clk), .I_RST (rst), .I_CFG_START (start_c),
        .O_CFG_BUSY (busy_c), .O_CFG_DONE (done_c), .O_CFG_ERR (err_c),
        .O_CFG_IDX (idx_c), .O_SCCB_DATA (data_c), .O_SCCB_START (sstart_c),
        .I_SCCB_BUSY (tie_lo), .I_SCCB_WAIT_INTR_CLR (tie_lo),
        .O_SCCB_INTR_CLR (clr_c)
    );

    // Behavioural SCCB master: busy for XFER_LEN+1 cycles, then wait for the interrupt clear
    int m_st [2];
    int m_cnt [2];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_st[k] <= 0; m_cnt[k] <= 0; m_busy[k] <= 1'b0; m_wait[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                case (m_st[k])
                    0: if (sccb_start[k]) begin
                        m_busy[k] <= 1'b1; m_cnt[k] <= 0; m_st[k] <= 1;
                    end
                    1: if (m_cnt[k] == XFER_LEN) begin
                        m_busy[k] <= 1'b0; m_wait[k] <= 1'b1; m_st[k] <= 2;
                    end else begin
                        m_cnt[k] <= m_cnt[k] + 1;
                    end
                    default: if (sccb_clr[k]) begin
                        m_wait[k] <= 1'b0; m_st[k] <= 0;
                    end
                endcase
            end
        end
    end

    // Frame log: data word and cycle of every START the master accepts
    logic [31:0] flog [2][16];
    int          fcyc [2][16];
    int          fcnt [2] = '{0, 0};
    logic [31:0] held [2];
    always @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (m_st[k] == 0 && sccb_start[k]) begin
                    if (fcnt[k] < 16) begin
                        flog[k][fcnt[k]] <= sccb_data[k];
                        fcyc[k][fcnt[k]] <= cyc;
                    end
                    fcnt[k] <= fcnt[k] + 1;
                    held[k] <= sccb_data[k];
                end
            end
        end
    end

    // Continuous protocol checks, summarised at the end
    int   overlap_cnt = 0;
    int   unstable_cnt = 0;
    int   idle_run [2] = '{0, 0};
    int   min_gap [2] = '{1000000, 1000000};
    logic after_frame [2] = '{1'b0, 1'b0};
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                idle_run[k] = 0;
                after_frame[k] = 1'b0;
            end else begin
                if (sccb_start[k] && sccb_clr[k]) overlap_cnt++;
                if ((m_busy[k] || m_wait[k]) && sccb_data[k] !== held[k]) unstable_cnt++;
                if (!(sccb_start[k] || m_busy[k] || m_wait[k] || sccb_clr[k])) begin
                    idle_run[k]++;
                end else begin
                    if (after_frame[k] && idle_run[k] > 0) begin
                        if (idle_run[k] < min_gap[k]) min_gap[k] = idle_run[k];
                        after_frame[k] = 1'b0;
                    end
                    idle_run[k] = 0;
                    if (sccb_clr[k]) after_frame[k] = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "simulation time limit");
    end

    logic [31:0] exp_b [4] = '{32'h00423A04, 32'h004240D0, 32'h00428C00, 32'h00421101};

    initial begin
        int n;
        rst = 1'b1;
        cfg_start = 2'b00;
        start_c = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", 32'(cfg_busy[0]), 0);
        chk("rst_done", 32'(cfg_done[0]), 0);
        chk("rst_err", 32'(cfg_err[0]), 0);
        chk("rst_idx", 32'(cfg_idx[0]), 0);
        chk("rst_data", sccb_data[0], 0);
        chk("rst_start_clr", 32'({sccb_start[0], sccb_clr[0]}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Watchdog: master never answers START
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        for (int i = 0; i < 50 && sstart_c !== 1'b1; i++) @(negedge clk);
        chk("c_launch_seen", 32'(sstart_c), 1);
        n = 0;
        while (sstart_c === 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
`ifdef OV7670_CFG_TIMEOUT_EN
        chk("c_launch_cycles", n, 64);
        chk("c_err", 32'(err_c), 1);
        chk("c_idx", 32'(idx_c), 0);
        chk("c_start", 32'(sstart_c), 0);
        chk("c_busy", 32'(busy_c), 0);
`else
        chk("c_launch_cycles", n, 300);
        chk("c_err", 32'(err_c), 0);
        chk("c_start", 32'(sstart_c), 1);
        chk("c_busy", 32'(busy_c), 1);
`endif

        // Table without END, NUM_ENTRIES=4
        cfg_start[1] = 1'b1;
        @(negedge clk);
        cfg_start[1] = 1'b0;
        for (int i = 0; i < 1000 && cfg_done[1] !== 1'b1; i++) @(negedge clk);
        chk("b_done", 32'(cfg_done[1]), 1);
        chk("b_idx", 32'(cfg_idx[1]), 4);
        chk("b_frames", fcnt[1], 4);
        for (int i = 0; i < 4; i++) chk($sformatf("b_frame%0d", i), flog[1][i], exp_b[i]);
        chk("b_min_gap", min_gap[1], 18);

        // Main table with a DELAY marker; extra start pulses mid-run are ignored
        cfg_start[0] = 1'b1;
        @(negedge clk);
        cfg_start[0] = 1'b0;
        chk("a_busy_after_start", 32'(cfg_busy[0]), 1);
        repeat (20) @(negedge clk);
        cfg_start[0] = 1'b1;
        @(negedge clk);
        cfg_start[0] = 1'b0;
        repeat (60) @(negedge clk);
        cfg_start[0] = 1'b1;
        @(negedge clk);
        cfg_start[0] = 1'b0;
        for (int i = 0; i < 1000 && cfg_done[0] !== 1'b1; i++) @(negedge clk);
        chk("a_done", 32'(cfg_done[0]), 1);
        chk("a_busy_end", 32'(cfg_busy[0]), 0);
        chk("a_idx", 32'(cfg_idx[0]), 3);
        chk("a_frames", fcnt[0], 2);
        chk("a_frame0", flog[0][0], 32'h00421280);
        chk("a_frame1", flog[0][1], 32'h00421101);
        chk("a_delay_spacing", fcyc[0][1] - fcyc[0][0], 129);

        // Restart after DONE repeats from index 0
        cfg_start[0] = 1'b1;
        @(negedge clk);
        cfg_start[0] = 1'b0;
        chk("a_restart_done_clr", 32'(cfg_done[0]), 0);
        chk("a_restart_busy", 32'(cfg_busy[0]), 1);
        for (int i = 0; i < 1000 && cfg_done[0] !== 1'b1; i++) @(negedge clk);
        chk("a_restart_done", 32'(cfg_done[0]), 1);
        chk("a_restart_frames", fcnt[0], 4);
        chk("a_frame2", flog[0][2], 32'h00421280);
        chk("a_frame3", flog[0][3], 32'h00421101);

        // Reset in the middle of the transfer of entry 2
        cfg_start[0] = 1'b1;
        @(negedge clk);
        cfg_start[0] = 1'b0;
        for (int i = 0; i < 1000 &&
             !(cfg_idx[0] == 8'd2 && m_busy[0] === 1'b1 && sccb_start[0] === 1'b0); i++)
            @(negedge clk);
        chk("a_in_xfer_idx2", 32'(cfg_idx[0] == 8'd2 && m_busy[0] === 1'b1), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("a_rst_busy", 32'(cfg_busy[0]), 0);
        chk("a_rst_idx", 32'(cfg_idx[0]), 0);
        chk("a_rst_data", sccb_data[0], 0);
        chk("a_rst_start_clr", 32'({sccb_start[0], sccb_clr[0], cfg_done[0]}), 0);
        rst = 1'b0;
        @(negedge clk);
        cfg_start[0] = 1'b1;
        @(negedge clk);
        cfg_start[0] = 1'b0;
        for (int i = 0; i < 1000 && cfg_done[0] !== 1'b1; i++) @(negedge clk);
        chk("a_post_rst_done", 32'(cfg_done[0]), 1);
        chk("a_post_rst_frames", fcnt[0], 8);
        chk("a_frame6", flog[0][6], 32'h00421280);
        chk("a_frame7", flog[0][7], 32'h00421101);

        // Protocol checks accumulated over the whole run
        repeat (2) @(negedge clk);
        chk("start_clr_overlap", overlap_cnt, 0);
        chk("data_unstable", unstable_cnt, 0);
        chk("a_min_gap_ge16", 32'(min_gap[0] >= 16), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
